h264_mem_arb: RTL
=================

H264_MEM_ARB -- requirements
Module: h264_mem_arb

Interface
REQ-001 Parameter AW, default 32, memory byte-address width.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Parameter MAX_BURST, default 16, maximum read beats per grant.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 rd_req  in  1  fetch read-burst request; held until rd_gnt.
REQ-007 rd_addr  in  AW  burst start byte address, word-aligned.
REQ-008 rd_len  in  5  requested beats.
REQ-009 rd_gnt  out  1  one-cycle pulse; the burst is accepted.
REQ-010 rd_valid  out  1  rd_data is valid.
REQ-011 rd_data  out  DW  returned read word.
REQ-012 rd_done  out  1  one-cycle pulse, coincident with the last rd_valid of the burst.
REQ-013 wr_req  in  1  packer single-word write request; held until wr_gnt.
REQ-014 wr_addr  in  AW  write byte address.
REQ-015 wr_data  in  DW  write word.
REQ-016 wr_gnt  out  1  one-cycle pulse; wr_addr and wr_data are captured.
REQ-017 mem_req  out  1  command valid to memory.
REQ-018 mem_we  out  1  1 = write command, 0 = read command.
REQ-019 mem_addr  out  AW  command address.
REQ-020 mem_wdata  out  DW  write data.
REQ-021 mem_ack  in  1  memory accepts the current command this cycle.
REQ-022 mem_rvalid  in  1  read data returned, in order, with arbitrary latency of at least 1 cycle.
REQ-023 mem_rdata  in  DW  read data.
REQ-024 err  out  1  sticky protocol error flag.

Function
REQ-025 The FSM SHALL have states IDLE, RD_CMD, RD_WAIT and WR.
REQ-026 In IDLE, the arbiter SHALL arbitrate round-robin using last_owner: a lone request wins; if both rd_req and wr_req are asserted, the requester not equal to last_owner wins.
REQ-027 A read grant SHALL pulse rd_gnt, latch rd_addr, latch len = (rd_len==0 ? 1 : min(rd_len, MAX_BURST)), set last_owner=RD, and move to RD_CMD.
REQ-028 A write grant SHALL pulse wr_gnt, latch wr_addr and wr_data, set last_owner=WR, and move to WR.
REQ-029 In RD_CMD, mem_req SHALL be 1 and mem_we SHALL be 0; on each mem_ack, cmd_addr SHALL increment by 4 (modulo 2^AW) and the remaining-command count SHALL decrement.
REQ-030 When the last read command is acked, the FSM SHALL go to RD_WAIT, or to IDLE if all beats have already returned.
REQ-031 Read returns SHALL be counted in RD_CMD and RD_WAIT; each mem_rvalid SHALL produce, one cycle later, rd_valid=1 with rd_data set to the registered mem_rdata.
REQ-032 On the final beat, rd_done SHALL be 1 together with rd_valid, and the FSM SHALL return to IDLE.
REQ-033 In WR, mem_req=1, mem_we=1, mem_addr=latched address and mem_wdata=latched data SHALL be driven until mem_ack, after which the FSM SHALL return to IDLE.
REQ-034 mem_req SHALL be 0 in IDLE and RD_WAIT; a new grant SHALL occur at the earliest in the cycle after the FSM re-enters IDLE.
REQ-035 mem_ack and mem_rvalid in the same cycle SHALL both be processed.
REQ-036 mem_ack while mem_req=0 SHALL be ignored.
REQ-037 mem_rvalid outside RD_CMD/RD_WAIT, or beyond len beats, SHALL be dropped and SHALL set err.
REQ-038 No grant SHALL be issued while a transaction is in progress; requests arriving then SHALL wait in the requester.
REQ-039 Counters SHALL be 5 bits; the remaining-beat count SHALL never underflow.

Reset
REQ-040 On rst low, the FSM SHALL go to IDLE asynchronously, last_owner SHALL be WR (so a read wins the first tie), and all counters and latched address/data SHALL clear.
REQ-041 During reset, all outputs SHALL be 0: rd_gnt, rd_valid, rd_data, rd_done, wr_gnt, mem_req, mem_we, mem_addr, mem_wdata and err.
REQ-042 A reset in mid-burst SHALL abandon the burst: no rd_done, and late mem_rvalid after release SHALL set err.

Verification
REQ-043 Read burst: rd_addr=0x100, rd_len=4, mem_ack always 1, rvalid latency 2 -> rd_gnt on cycle 1; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 rd_valid; rd_done on the 4th.
REQ-044 Tie: rd_req and wr_req asserted together after reset -> read granted first; write granted in the cycle after rd_done returns the FSM to IDLE; with both still requesting, the next grants alternate RD/WR.
REQ-045 Length clamp: rd_len=0 -> 1 beat; rd_len=20 -> 16 beats; rd_addr=0xFFFFFFFC with len 2 -> second address 0x00000000.
REQ-046 Write stall: wr_addr=0x200, wr_data=0xDEADBEEF, mem_ack held low 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; IDLE after ack.
REQ-047 Protocol error: mem_rvalid in IDLE -> err=1 and it stays 1 until reset; rd_valid stays 0.
REQ-048 Reset mid-burst after 2 of 8 beats -> all outputs 0 immediately; a later rvalid sets err.

Source files
------------

// File: rtl/h264_mem_arb_if.sv
// rtl/h264_mem_arb_if.sv - fetch/packer/memory handshake bundle for the H.264 memory arbiter
interface h264_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [4:0]    rd_len;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_done;

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    logic          err;

    // Arbiter side
    modport slave (
        input  rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_data,
        input  mem_ack, mem_rvalid, mem_rdata,
        output rd_gnt, rd_valid, rd_data, rd_done, wr_gnt,
        output mem_req, mem_we, mem_addr, mem_wdata, err
    );

    // Requester and memory side
    modport master (
        output rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_data,
        output mem_ack, mem_rvalid, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, rd_done, wr_gnt,
        input  mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/h264_mem_arb.sv
// rtl/h264_mem_arb.sv - round-robin arbiter between fetch read bursts and packer single writes
module h264_mem_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           rst,
    h264_mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR} state_t;

    localparam logic       OWN_RD  = 1'b0;
    localparam logic       OWN_WR  = 1'b1;
    localparam logic [4:0] MAX_LEN = 5'(MAX_BURST);

    state_t        state;
    logic          last_owner;
    logic [4:0]    rem_cmd;
    logic [4:0]    rem_beat;

    logic          rd_gnt_q;
    logic          wr_gnt_q;
    logic          rd_valid_q;
    logic          rd_done_q;
    logic [DW-1:0] rd_data_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          err_q;

    logic          pick_rd;
    logic          pick_wr;
    logic [4:0]    clamp_len;
    logic          cmd_fire;
    logic          beat_ok;
    logic          beat_bad;
    logic          last_beat;

    // Grant choice, burst length clamp and per-cycle event decode
    always_comb begin
        pick_rd   = bus.rd_req && (!bus.wr_req || last_owner == OWN_WR);
        pick_wr   = bus.wr_req && !pick_rd;
        clamp_len = bus.rd_len;
        if (bus.rd_len == 5'd0) begin
            clamp_len = 5'd1;
        end else if (bus.rd_len > MAX_LEN) begin
            clamp_len = MAX_LEN;
        end
        // Acks only count while a command is actually being offered
        cmd_fire  = mem_req_q && bus.mem_ack;
        // A return is only accepted inside a read burst with beats still owed
        beat_ok   = bus.mem_rvalid && (state == RD_CMD || state == RD_WAIT) && (rem_beat != 5'd0);
        beat_bad  = bus.mem_rvalid && !beat_ok;
        last_beat = beat_ok && (rem_beat == 5'd1);
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_owner  <= OWN_WR;
            rem_cmd     <= 5'd0;
            rem_beat    <= 5'd0;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;

            if (beat_bad) begin
                err_q <= 1'b1;
            end
            if (beat_ok) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= bus.mem_rdata;
                rem_beat   <= rem_beat - 5'd1;
                if (last_beat) begin
                    rd_done_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (pick_rd) begin
                        rd_gnt_q   <= 1'b1;
                        mem_addr_q <= bus.rd_addr;
                        rem_cmd    <= clamp_len;
                        rem_beat   <= clamp_len;
                        last_owner <= OWN_RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        state      <= RD_CMD;
                    end else if (pick_wr) begin
                        wr_gnt_q    <= 1'b1;
                        mem_addr_q  <= bus.wr_addr;
                        mem_wdata_q <= bus.wr_data;
                        last_owner  <= OWN_WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        state       <= WR;
                    end
                end
                RD_CMD: begin
                    if (cmd_fire && rem_cmd != 5'd0) begin
                        mem_addr_q <= mem_addr_q + AW'(4);
                        rem_cmd    <= rem_cmd - 5'd1;
                    end
                    if (last_beat) begin
                        mem_req_q <= 1'b0;
                        state     <= IDLE;
                    end else if (cmd_fire && rem_cmd == 5'd1) begin
                        mem_req_q <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (cmd_fire) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_gnt    = rd_gnt_q;
    assign bus.wr_gnt    = wr_gnt_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;
endmodule
